// File: rtl/memory_access_pkg.sv
// Shared types and constants for the memory access stage.
package memory_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_DONE    = 2'd3
  } mau_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  function automatic mem_size_t decode_size(input logic is_byte, input logic is_half);
    if (is_byte)      return SZ_BYTE;
    else if (is_half) return SZ_HALF;
    else              return SZ_WORD;
  endfunction

endpackage

// File: rtl/memory_access_unit_if.sv
// Memory controller request/read-return bus.
interface memory_access_unit_if #(
  parameter int X_LENGTH     = 32,
  parameter int MEMORY_WIDTH = 32
);
  logic                    memory_req_valid;
  logic                    memory_req_ready;
  logic [X_LENGTH-1:0]     memory_addr;
  logic                    memory_write_enable;
  logic [3:0]              memory_write_strobe;
  logic [MEMORY_WIDTH-1:0] memory_write_data;
  logic                    memory_read_valid;
  logic [MEMORY_WIDTH-1:0] memory_read_data;

  modport master (
    output memory_req_valid, memory_addr, memory_write_enable,
           memory_write_strobe, memory_write_data,
    input  memory_req_ready, memory_read_valid, memory_read_data
  );

  modport slave (
    input  memory_req_valid, memory_addr, memory_write_enable,
           memory_write_strobe, memory_write_data,
    output memory_req_ready, memory_read_valid, memory_read_data
  );
endinterface

// File: rtl/load_store_aligner.sv
// Byte-lane steering for stores and extraction/extension for loads on a 32-bit bus.
module load_store_aligner
  import memory_access_pkg::*;
(
  input  mem_size_t   size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] read_word,
  output logic [3:0]  strobe,
  output logic [31:0] write_data,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte    = read_word[{offset, 3'b000} +: 8];
    rd_half    = offset[1] ? read_word[31:16] : read_word[15:0];
    strobe     = '0;
    write_data = '0;
    load_data  = '0;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        strobe     = STRB_BYTE << offset;
        write_data = {4{store_data[7:0]}};
        load_data  = sign_ext ? {{24{rd_byte[7]}}, rd_byte} : {24'b0, rd_byte};
      end
      SZ_HALF: begin
        misaligned = offset[0];
        strobe     = STRB_HALF << offset;
        write_data = {2{store_data[15:0]}};
        load_data  = sign_ext ? {{16{rd_half[15]}}, rd_half} : {16'b0, rd_half};
      end
      default: begin
        misaligned = |offset;
        strobe     = STRB_WORD;
        write_data = store_data;
        load_data  = read_word;
      end
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// RV32I load/store stage: one instruction in flight, registered bus and writeback outputs.
module memory_access_unit
  import memory_access_pkg::*;
#(
  parameter int X_LENGTH     = 32,
  parameter int MEMORY_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic                rv32_s_sb,
  input  logic                rv32_s_sh,
  input  logic                rv32_s_sw,
  input  logic                rv32_i_lb,
  input  logic                rv32_i_lh,
  input  logic                rv32_i_lw,
  input  logic                rv32_i_lbu,
  input  logic                rv32_i_lhu,
  input  logic [4:0]          rv32_rd_addr,
  input  logic                rv32_rd_we,
  input  logic [X_LENGTH-1:0] alu_result,
  input  logic [X_LENGTH-1:0] rv32_rs2_data,
  memory_access_unit_if.master mem,
  output logic                wb_valid,
  output logic [4:0]          wb_rd_addr,
  output logic [X_LENGTH-1:0] wb_rd_data,
  output logic                wb_rd_we,
  output logic                misaligned_exception
);

  mau_state_e state_q, state_d;
  logic                    ex_ready_q, ex_ready_d;
  logic                    req_valid_q, req_valid_d;
  logic [X_LENGTH-1:0]     addr_q, addr_d;
  logic                    we_q, we_d;
  logic [3:0]              strb_q, strb_d;
  logic [MEMORY_WIDTH-1:0] wdata_q, wdata_d;
  logic                    wb_valid_q, wb_valid_d;
  logic [4:0]              wb_rd_addr_q, wb_rd_addr_d;
  logic [X_LENGTH-1:0]     wb_rd_data_q, wb_rd_data_d;
  logic                    wb_rd_we_q, wb_rd_we_d;
  logic                    mis_q, mis_d;
  logic [4:0]              rd_q, rd_d;
  logic                    rd_we_q, rd_we_d;
  logic                    store_q, store_d;
  mem_size_t               size_q, size_d;
  logic                    sign_q, sign_d;
  logic [1:0]              off_q, off_d;

  logic      is_load, is_store, in_idle;
  mem_size_t live_size, aln_size;
  logic      aln_sign, aln_mis;
  logic [1:0] aln_off;
  logic [3:0] aln_strb;
  logic [MEMORY_WIDTH-1:0] aln_wdata, aln_ld;

  assign is_load   = rv32_i_lb | rv32_i_lh | rv32_i_lw | rv32_i_lbu | rv32_i_lhu;
  assign is_store  = rv32_s_sb | rv32_s_sh | rv32_s_sw;
  assign live_size = decode_size(rv32_s_sb | rv32_i_lb | rv32_i_lbu,
                                 rv32_s_sh | rv32_i_lh | rv32_i_lhu);
  assign in_idle   = (state_q == ST_IDLE);

  // One aligner serves both phases: live inputs at accept, captured ones on read return.
  assign aln_size = in_idle ? live_size : size_q;
  assign aln_sign = in_idle ? (rv32_i_lb | rv32_i_lh) : sign_q;
  assign aln_off  = in_idle ? alu_result[1:0] : off_q;

  load_store_aligner u_aligner (
    .size       (aln_size),
    .sign_ext   (aln_sign),
    .offset     (aln_off),
    .store_data (rv32_rs2_data),
    .read_word  (mem.memory_read_data),
    .strobe     (aln_strb),
    .write_data (aln_wdata),
    .load_data  (aln_ld),
    .misaligned (aln_mis)
  );

  always_comb begin
    state_d      = state_q;
    req_valid_d  = req_valid_q;
    addr_d       = addr_q;
    we_d         = we_q;
    strb_d       = strb_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    rd_we_d      = rd_we_q;
    store_d      = store_q;
    size_d       = size_q;
    sign_d       = sign_q;
    off_d        = off_q;
    wb_valid_d   = 1'b0;
    wb_rd_addr_d = '0;
    wb_rd_data_d = '0;
    wb_rd_we_d   = 1'b0;
    mis_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid && ex_ready_q) begin
          rd_d    = rv32_rd_addr;
          rd_we_d = rv32_rd_we;
          store_d = is_store;
          size_d  = live_size;
          sign_d  = rv32_i_lb | rv32_i_lh;
          off_d   = alu_result[1:0];
          if (!is_load && !is_store) begin
            state_d      = ST_DONE;
            wb_valid_d   = 1'b1;
            wb_rd_addr_d = rv32_rd_addr;
            wb_rd_data_d = alu_result;
            wb_rd_we_d   = rv32_rd_we && (rv32_rd_addr != 5'd0);
          end else if (aln_mis) begin
            state_d      = ST_DONE;
            wb_valid_d   = 1'b1;
            wb_rd_addr_d = rv32_rd_addr;
            mis_d        = 1'b1;
          end else begin
            state_d     = ST_REQ;
            req_valid_d = 1'b1;
            addr_d      = {alu_result[X_LENGTH-1:2], 2'b00};
            we_d        = is_store;
            strb_d      = aln_strb;
            wdata_d     = is_store ? aln_wdata : '0;
          end
        end
      end
      ST_REQ: begin
        if (mem.memory_req_ready) begin
          req_valid_d = 1'b0;
          if (store_q) begin
            state_d      = ST_DONE;
            wb_valid_d   = 1'b1;
            wb_rd_addr_d = rd_q;
          end else if (mem.memory_read_valid) begin
            state_d      = ST_DONE;
            wb_valid_d   = 1'b1;
            wb_rd_addr_d = rd_q;
            wb_rd_data_d = aln_ld;
            wb_rd_we_d   = rd_we_q && (rd_q != 5'd0);
          end else begin
            state_d = ST_WAIT_RD;
          end
        end
      end
      ST_WAIT_RD: begin
        if (mem.memory_read_valid) begin
          state_d      = ST_DONE;
          wb_valid_d   = 1'b1;
          wb_rd_addr_d = rd_q;
          wb_rd_data_d = aln_ld;
          wb_rd_we_d   = rd_we_q && (rd_q != 5'd0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ex_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ex_ready_q   <= 1'b0;
      req_valid_q  <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      strb_q       <= '0;
      wdata_q      <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_addr_q <= '0;
      wb_rd_data_q <= '0;
      wb_rd_we_q   <= 1'b0;
      mis_q        <= 1'b0;
      rd_q         <= '0;
      rd_we_q      <= 1'b0;
      store_q      <= 1'b0;
      size_q       <= SZ_BYTE;
      sign_q       <= 1'b0;
      off_q        <= '0;
    end else begin
      state_q      <= state_d;
      ex_ready_q   <= ex_ready_d;
      req_valid_q  <= req_valid_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      strb_q       <= strb_d;
      wdata_q      <= wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_rd_data_q <= wb_rd_data_d;
      wb_rd_we_q   <= wb_rd_we_d;
      mis_q        <= mis_d;
      rd_q         <= rd_d;
      rd_we_q      <= rd_we_d;
      store_q      <= store_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      off_q        <= off_d;
    end
  end

  assign ex_ready                 = ex_ready_q;
  assign mem.memory_req_valid     = req_valid_q;
  assign mem.memory_addr          = addr_q;
  assign mem.memory_write_enable  = we_q;
  assign mem.memory_write_strobe  = strb_q;
  assign mem.memory_write_data    = wdata_q;
  assign wb_valid                 = wb_valid_q;
  assign wb_rd_addr               = wb_rd_addr_q;
  assign wb_rd_data               = wb_rd_data_q;
  assign wb_rd_we                 = wb_rd_we_q;
  assign misaligned_exception     = mis_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Vector table plus scoreboard for memory_access_unit, with a reset-mid-load sequence.
module tb_memory_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ex_valid, ex_ready;
  logic        sb, sh, sw, lb, lh, lw, lbu, lhu;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic [31:0] alu_result, rs2_data;
  logic        wb_valid, wb_rd_we, mis_exc;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;

  memory_access_unit_if #(.X_LENGTH(32), .MEMORY_WIDTH(32)) mem_if ();

  memory_access_unit #(.X_LENGTH(32), .MEMORY_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .rv32_s_sb(sb), .rv32_s_sh(sh), .rv32_s_sw(sw),
    .rv32_i_lb(lb), .rv32_i_lh(lh), .rv32_i_lw(lw), .rv32_i_lbu(lbu), .rv32_i_lhu(lhu),
    .rv32_rd_addr(rd_addr), .rv32_rd_we(rd_we), .alu_result(alu_result),
    .rv32_rs2_data(rs2_data), .mem(mem_if.master),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .wb_rd_we(wb_rd_we), .misaligned_exception(mis_exc)
  );

  // op: 0 none, 1 sb, 2 sh, 3 sw, 4 lb, 5 lh, 6 lw, 7 lbu, 8 lhu
  typedef struct {
    int          op;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] rdata;
    int          req_wait;
    int          rd_wait;
    logic        exp_req;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
    logic        exp_we;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[13];
  vec_t sb_q[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(int op, logic [31:0] addr, logic [31:0] rs2, logic [4:0] rd,
                              logic rd_we, logic [31:0] rdata, int req_wait, int rd_wait,
                              logic exp_req, logic [3:0] exp_strb, logic [31:0] exp_wdata,
                              logic [31:0] exp_data, logic exp_we, logic exp_mis);
    vec_t v;
    v.op = op; v.addr = addr; v.rs2 = rs2; v.rd = rd; v.rd_we = rd_we; v.rdata = rdata;
    v.req_wait = req_wait; v.rd_wait = rd_wait; v.exp_req = exp_req; v.exp_strb = exp_strb;
    v.exp_wdata = exp_wdata; v.exp_data = exp_data; v.exp_we = exp_we; v.exp_mis = exp_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_op(input int op);
    {sb, sh, sw, lb, lh, lw, lbu, lhu} = 8'b0;
    case (op)
      1: sb = 1'b1;  2: sh = 1'b1;  3: sw = 1'b1;
      4: lb = 1'b1;  5: lh = 1'b1;  6: lw = 1'b1;
      7: lbu = 1'b1; 8: lhu = 1'b1;
      default: ;
    endcase
  endtask

  task automatic clear_bus;
    mem_if.memory_req_ready  = 1'b0;
    mem_if.memory_read_valid = 1'b0;
    mem_if.memory_read_data  = 32'hDEAD_BEEF;
  endtask

  task automatic do_op(input vec_t v);
    int n, lat, req_cnt, rd_cnt, exp_lat;
    bit got_wb, seen_req, rdy_done, rd_done, is_ld, is_st;
    logic [31:0] a0, d0;
    logic [3:0]  s0;
    vec_t e;
    is_ld = (v.op >= 4); is_st = (v.op >= 1 && v.op <= 3);
    exp_lat = !v.exp_req ? 1 : 2 + v.req_wait + (is_ld ? v.rd_wait : 0);
    n = 0;
    while (!ex_ready && n < 20) begin @(negedge clk); n++; end
    if (!ex_ready) begin chk("ex_ready_wait", 32'd0, 32'd1); return; end
    set_op(v.op);
    alu_result = v.addr; rs2_data = v.rs2; rd_addr = v.rd; rd_we = v.rd_we; ex_valid = 1'b1;
    sb_q.push_back(v);
    @(negedge clk);
    ex_valid = 1'b0; set_op(0);
    got_wb = 0; seen_req = 0; rdy_done = 0; rd_done = 0; req_cnt = 0; rd_cnt = 0;
    a0 = '0; d0 = '0; s0 = '0;
    for (lat = 1; lat <= 40; lat++) begin
      if (mem_if.memory_req_valid) begin
        if (!seen_req) begin
          seen_req = 1;
          a0 = mem_if.memory_addr; s0 = mem_if.memory_write_strobe; d0 = mem_if.memory_write_data;
          chk("req_addr", mem_if.memory_addr, {v.addr[31:2], 2'b00});
          chk("req_we", {31'b0, mem_if.memory_write_enable}, {31'b0, is_st});
          if (is_st) begin
            chk("req_strobe", {28'b0, mem_if.memory_write_strobe}, {28'b0, v.exp_strb});
            chk("req_wdata", mem_if.memory_write_data, v.exp_wdata);
          end
        end else begin
          chk("req_stable", {mem_if.memory_addr ^ a0} | {28'b0, mem_if.memory_write_strobe ^ s0}
                            | (mem_if.memory_write_data ^ d0), 32'd0);
        end
      end
      if (wb_valid) begin
        got_wb = 1;
        if (sb_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("wb_rd_data", wb_rd_data, e.exp_data);
          chk("wb_rd_addr", {27'b0, wb_rd_addr}, {27'b0, e.rd});
          chk("wb_rd_we", {31'b0, wb_rd_we}, {31'b0, e.exp_we});
          chk("misaligned", {31'b0, mis_exc}, {31'b0, e.exp_mis});
          chk("req_seen", {31'b0, seen_req}, {31'b0, e.exp_req});
          chk("latency", lat, exp_lat);
        end
        break;
      end
      clear_bus();
      if (mem_if.memory_req_valid && !rdy_done) begin
        if (req_cnt == v.req_wait) begin
          mem_if.memory_req_ready = 1'b1; rdy_done = 1;
          if (is_ld && v.rd_wait == 0) begin
            mem_if.memory_read_valid = 1'b1; mem_if.memory_read_data = v.rdata; rd_done = 1;
          end
        end else req_cnt++;
      end else if (rdy_done && is_ld && !rd_done) begin
        rd_cnt++;
        if (rd_cnt == v.rd_wait) begin
          mem_if.memory_read_valid = 1'b1; mem_if.memory_read_data = v.rdata; rd_done = 1;
        end
      end
      @(negedge clk);
    end
    clear_bus();
    if (!got_wb) chk("wb_timeout", 32'd0, 32'd1);
    else begin
      @(negedge clk);
      chk("wb_pulse_len", {31'b0, wb_valid}, 32'd0);
      chk("mis_pulse_len", {31'b0, mis_exc}, 32'd0);
    end
  endtask

  initial begin
    ex_valid = 0; set_op(0); rd_addr = 0; rd_we = 0; alu_result = 0; rs2_data = 0;
    clear_bus();

    //            op addr          rs2           rd  we rdata         rq rw req strb     wdata         data          we mis
    vecs[0]  = mk(0, 32'h20,       32'h0,        5,  1, 32'h0,         0, 0, 0, 4'b0000, 32'h0,        32'h20,       1, 0);
    vecs[1]  = mk(0, 32'h1234,     32'h0,        0,  1, 32'h0,         0, 0, 0, 4'b0000, 32'h0,        32'h1234,     0, 0);
    vecs[2]  = mk(1, 32'h103,      32'hA5,       9,  1, 32'h0,         2, 0, 1, 4'b1000, 32'hA5A5A5A5, 32'h0,        0, 0);
    vecs[3]  = mk(2, 32'h202,      32'h1234BEEF, 2,  0, 32'h0,         0, 0, 1, 4'b1100, 32'hBEEFBEEF, 32'h0,        0, 0);
    vecs[4]  = mk(3, 32'h300,      32'hCAFEF00D, 2,  0, 32'h0,         1, 0, 1, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 0);
    vecs[5]  = mk(4, 32'h102,      32'h0,        7,  1, 32'h00800000,  0, 3, 1, 4'b0000, 32'h0,        32'hFFFFFF80, 1, 0);
    vecs[6]  = mk(7, 32'h102,      32'h0,        8,  1, 32'h00800000,  0, 3, 1, 4'b0000, 32'h0,        32'h00000080, 1, 0);
    vecs[7]  = mk(6, 32'h102,      32'h0,        3,  1, 32'h0,         0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 1);
    vecs[8]  = mk(8, 32'h2,        32'h0,        10, 1, 32'hBEEF0000,  0, 0, 1, 4'b0000, 32'h0,        32'h0000BEEF, 1, 0);
    vecs[9]  = mk(5, 32'h0,        32'h0,        11, 1, 32'h12348001,  0, 1, 1, 4'b0000, 32'h0,        32'hFFFF8001, 1, 0);
    vecs[10] = mk(6, 32'h104,      32'h0,        0,  1, 32'h89ABCDEF,  1, 2, 1, 4'b0000, 32'h0,        32'h89ABCDEF, 0, 0);
    vecs[11] = mk(2, 32'h201,      32'h5555,     12, 1, 32'h0,         0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 1);
    vecs[12] = mk(4, 32'h101,      32'h0,        13, 1, 32'h00007F00,  2, 1, 1, 4'b0000, 32'h0,        32'h0000007F, 1, 0);

    repeat (2) @(negedge clk);
    chk("rst_ex_ready", {31'b0, ex_ready}, 32'd0);
    chk("rst_req_valid", {31'b0, mem_if.memory_req_valid}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_rd_data, 32'd0);
    chk("rst_addr", mem_if.memory_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ex_ready_after_rst", {31'b0, ex_ready}, 32'd1);

    for (int i = 0; i < 13; i++) do_op(vecs[i]);

    // Reset while waiting for read data, then a stale read return.
    set_op(4); alu_result = 32'h100; rd_addr = 5'd4; rd_we = 1'b1; ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0; set_op(0);
    chk("midrst_req", {31'b0, mem_if.memory_req_valid}, 32'd1);
    mem_if.memory_req_ready = 1'b1;
    @(negedge clk);
    clear_bus();
    chk("midrst_waitrd", {31'b0, mem_if.memory_req_valid | ex_ready}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_outs", {26'b0, mem_if.memory_req_valid, wb_valid, wb_rd_we, mis_exc,
                        ex_ready, mem_if.memory_write_enable}, 32'd0);
    chk("midrst_addr", mem_if.memory_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ex_ready", {31'b0, ex_ready}, 32'd1);
    mem_if.memory_read_valid = 1'b1; mem_if.memory_read_data = 32'h80;
    @(negedge clk);
    clear_bus();
    chk("stale_rd_wb", {31'b0, wb_valid}, 32'd0);
    @(negedge clk);
    chk("stale_rd_wb2", {30'b0, wb_valid, mem_if.memory_req_valid}, 32'd0);

    do_op(vecs[0]);
    chk("scoreboard_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
